// File: rtl/qbus_arbiter3_if.sv
// Bundle of every request/response signal around the three-master qbus arbiter.
// Ports: instr_m_* (fetch master), data_m_* (CPU data master), dma_m_* (DMA master),
//        q_m_* (shared slave bus), bus_error / bus_error_clr (sticky timeout flag).
// Modport slave is the arbiter's view; modport master is the masters-plus-memory view.
interface qbus_arbiter3_if;
    // instruction master
    logic [18:0] instr_m_addr;
    logic        instr_m_access;
    logic        instr_m_ack;
    logic [15:0] instr_m_data_in;
    // data master
    logic [18:0] data_m_addr;
    logic [15:0] data_m_data_out;
    logic        data_m_access;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;
    logic        data_m_ack;
    logic [15:0] data_m_data_in;
    // DMA master
    logic [18:0] dma_m_addr;
    logic [15:0] dma_m_data_out;
    logic        dma_m_access;
    logic        dma_m_wr_en;
    logic [1:0]  dma_m_bytesel;
    logic        dma_m_ack;
    logic [15:0] dma_m_data_in;
    // shared slave bus
    logic [18:0] q_m_addr;
    logic [15:0] q_m_data_out;
    logic        q_m_access;
    logic        q_m_wr_en;
    logic [1:0]  q_m_bytesel;
    logic        q_m_ack;
    logic [15:0] q_m_data_in;
    // error reporting
    logic        bus_error;
    logic        bus_error_clr;

    modport slave (
        input  instr_m_addr, instr_m_access,
        output instr_m_ack, instr_m_data_in,
        input  data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel,
        output data_m_ack, data_m_data_in,
        input  dma_m_addr, dma_m_data_out, dma_m_access, dma_m_wr_en, dma_m_bytesel,
        output dma_m_ack, dma_m_data_in,
        output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        input  q_m_ack, q_m_data_in,
        output bus_error,
        input  bus_error_clr
    );

    modport master (
        output instr_m_addr, instr_m_access,
        input  instr_m_ack, instr_m_data_in,
        output data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel,
        input  data_m_ack, data_m_data_in,
        output dma_m_addr, dma_m_data_out, dma_m_access, dma_m_wr_en, dma_m_bytesel,
        input  dma_m_ack, dma_m_data_in,
        input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        output q_m_ack, q_m_data_in,
        input  bus_error,
        output bus_error_clr
    );
endinterface

// File: rtl/qbus_arbiter3.sv
// Round-robin arbiter: INSTR(0)/DATA(1)/DMA(2) onto the shared q_m_* memory bus, one transaction at a time.
// Latency: grant decided in IDLE, q_m_access one cycle later; slave ack routed back combinationally; one IDLE bubble after.
// Backpressure: masters hold *_access and their signals until their ack; the grant is held until q_m_ack.
// Ports: clk, reset (async active-high), bus (qbus_arbiter3_if.slave).
// Optional: QBUS_ARB_ACK_TIMEOUT_EN adds a TIMEOUT-cycle ack watchdog that force-completes with 16'hFFFF and sets bus_error.
module qbus_arbiter3 #(
    parameter int TIMEOUT = 1024,  // >= 4
    parameter int CNT_W   = 11     // must hold TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    qbus_arbiter3_if.slave   bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] M_INSTR = 2'd0;
    localparam logic [1:0] M_DATA  = 2'd1;
    localparam logic [1:0] M_DMA   = 2'd2;
    localparam logic [1:0] M_NONE  = 2'd3;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_q;
    logic [2:0]  req;
    logic [1:0]  pick;
    logic        to_hit;     // watchdog forces completion this cycle
    logic        done;
    logic [15:0] rdata;

    // First requester scanning upward from the master after the last winner.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] o0, o1, o2, res;
        case (last)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (r[o0])      res = o0;
        else if (r[o1]) res = o1;
        else if (r[o2]) res = o2;
        else            res = M_NONE;
        return res;
    endfunction

    assign req  = {bus.dma_m_access, bus.data_m_access, bus.instr_m_access};
    assign pick = rr_pick(req, last_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= M_NONE;
            last_q  <= M_INSTR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick != M_NONE) begin
                        state_q <= BUSY;
                        grant_q <= pick;
                        last_q  <= pick;
                    end
                end
                BUSY: begin
                    // Access drops by the granted master are ignored; only completion ends BUSY.
                    if (done) begin
                        state_q <= IDLE;
                        grant_q <= M_NONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef QBUS_ARB_ACK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             bus_error_q;

    // A real ack in the same cycle wins over the watchdog.
    assign to_hit = (state_q == BUSY) && !bus.q_m_ack && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            // Held at zero in IDLE so every BUSY entry starts from zero.
            if (state_q == IDLE)
                cnt_q <= '0;
            else if (!bus.q_m_ack)
                cnt_q <= cnt_q + 1'b1;

            if (to_hit)
                bus_error_q <= 1'b1;
            else if (bus.bus_error_clr)
                bus_error_q <= 1'b0;
        end
    end

    assign bus.bus_error = bus_error_q;
`else
    wire [CNT_W:0] unused_cfg = {bus.bus_error_clr, CNT_W'(TIMEOUT - 1)};

    assign to_hit        = 1'b0;
    assign bus.bus_error = 1'b0;
`endif

    assign done  = bus.q_m_ack || to_hit;
    assign rdata = to_hit ? 16'hFFFF : bus.q_m_data_in;

    always_comb begin
        bus.q_m_access      = 1'b0;
        bus.q_m_addr        = '0;
        bus.q_m_data_out    = '0;
        bus.q_m_wr_en       = 1'b0;
        bus.q_m_bytesel     = '0;
        bus.instr_m_ack     = 1'b0;
        bus.instr_m_data_in = '0;
        bus.data_m_ack      = 1'b0;
        bus.data_m_data_in  = '0;
        bus.dma_m_ack       = 1'b0;
        bus.dma_m_data_in   = '0;
        if (state_q == BUSY) begin
            bus.q_m_access = !to_hit;
            case (grant_q)
                M_INSTR: begin
                    // Fetches are always full-word reads.
                    bus.q_m_addr        = bus.instr_m_addr;
                    bus.q_m_bytesel     = 2'b11;
                    bus.instr_m_ack     = done;
                    bus.instr_m_data_in = rdata;
                end
                M_DATA: begin
                    bus.q_m_addr       = bus.data_m_addr;
                    bus.q_m_data_out   = bus.data_m_data_out;
                    bus.q_m_wr_en      = bus.data_m_wr_en;
                    bus.q_m_bytesel    = bus.data_m_bytesel;
                    bus.data_m_ack     = done;
                    bus.data_m_data_in = rdata;
                end
                M_DMA: begin
                    bus.q_m_addr      = bus.dma_m_addr;
                    bus.q_m_data_out  = bus.dma_m_data_out;
                    bus.q_m_wr_en     = bus.dma_m_wr_en;
                    bus.q_m_bytesel   = bus.dma_m_bytesel;
                    bus.dma_m_ack     = done;
                    bus.dma_m_data_in = rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qbus_arbiter3.sv
module tb_qbus_arbiter3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qbus_arbiter3_if bus();

    qbus_arbiter3 #(.TIMEOUT(8), .CNT_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_acks   = 0;
    int cyc      = 0;

    logic        slave_en  = 1'b1;
    int          slave_lat = 3;
    logic        force_en  = 1'b0;
    logic [15:0] force_data = 16'h0;

    always @(posedge clk) cyc++;

    // Memory contents model
    function automatic logic [15:0] mem_rd(input logic [18:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave: acks slave_lat cycles after q_m_access rises
    initial begin
        int busy_n;
        busy_n = 0;
        bus.q_m_ack     = 1'b0;
        bus.q_m_data_in = 16'h0;
        forever begin
            @(posedge clk); #1;
            bus.q_m_ack     = 1'b0;
            bus.q_m_data_in = 16'h0;
            if (bus.q_m_access) begin
                if (slave_en && busy_n >= slave_lat) begin
                    bus.q_m_ack     = 1'b1;
                    bus.q_m_data_in = force_en ? force_data : mem_rd(bus.q_m_addr);
                    busy_n = 0;
                end else begin
                    busy_n++;
                end
            end else begin
                busy_n = 0;
            end
        end
    end

    // Ack monitor: pops the scoreboard on every completion
    initial begin
        logic [2:0]  acks;
        logic [1:0]  id;
        logic [15:0] dat;
        logic [15:0] others;
        exp_t        e;
        forever begin
            @(negedge clk);
            acks = {bus.dma_m_ack, bus.data_m_ack, bus.instr_m_ack};
            if (acks != 3'b000) begin
                n_acks++;
                check_eq("ack_onehot", $countones(acks), 1);
                if (acks[2]) begin
                    id = 2'd2; dat = bus.dma_m_data_in;
                    others = bus.instr_m_data_in | bus.data_m_data_in;
                end else if (acks[1]) begin
                    id = 2'd1; dat = bus.data_m_data_in;
                    others = bus.instr_m_data_in | bus.dma_m_data_in;
                end else begin
                    id = 2'd0; dat = bus.instr_m_data_in;
                    others = bus.data_m_data_in | bus.dma_m_data_in;
                end
                if (sb.size() > 0) e = sb.pop_front();
                else e = '{id: 2'd3, data: 16'h0};
                check_eq("ack_master", id, e.id);
                check_eq("ack_data", dat, e.data);
                check_eq("nongranted_data_in", others, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_acks(input int target);
        int g;
        g = 0;
        while (n_acks < target && g < 200) begin
            tick();
            g++;
        end
        check_eq("ack_arrived", n_acks >= target, 1);
    endtask

    task automatic wait_access(input string tag);
        int g;
        g = 0;
        while (!bus.q_m_access && g < 50) begin
            tick();
            g++;
        end
        check_eq(tag, bus.q_m_access, 1);
    endtask

    // Checks {addr, data_out, wr_en, bytesel} on every BUSY cycle of one grant
    task automatic watch_busy(input string tag, input logic [37:0] exp_ctl);
        int g;
        g = 0;
        wait_access({tag, "_start"});
        while (bus.q_m_access && g < 50) begin
            check_eq(tag, {bus.q_m_addr, bus.q_m_data_out, bus.q_m_wr_en, bus.q_m_bytesel}, exp_ctl);
            tick();
            g++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int base;
        int rise;
        int busy;
        int g;
        bus.instr_m_addr = '0; bus.instr_m_access = 1'b0;
        bus.data_m_addr = '0; bus.data_m_data_out = '0; bus.data_m_access = 1'b0;
        bus.data_m_wr_en = 1'b0; bus.data_m_bytesel = 2'b11;
        bus.dma_m_addr = '0; bus.dma_m_data_out = '0; bus.dma_m_access = 1'b0;
        bus.dma_m_wr_en = 1'b0; bus.dma_m_bytesel = 2'b11;
        bus.bus_error_clr = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_access", bus.q_m_access, 0);
        check_eq("rst_acks", {bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack}, 0);
        check_eq("rst_bus_error", bus.bus_error, 0);
        check_eq("rst_q_bus", {bus.q_m_addr, bus.q_m_data_out, bus.q_m_wr_en, bus.q_m_bytesel}, 0);
        reset = 1'b0;
        tick();

        // All three request continuously: DATA, DMA, INSTR, ...
        base = n_acks;
        bus.instr_m_addr = 19'h01000;
        bus.data_m_addr  = 19'h02000;
        bus.dma_m_addr   = 19'h03000;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{id: 2'd1, data: mem_rd(19'h02000)});
            sb.push_back('{id: 2'd2, data: mem_rd(19'h03000)});
            sb.push_back('{id: 2'd0, data: mem_rd(19'h01000)});
        end
        bus.instr_m_access = 1'b1; bus.data_m_access = 1'b1; bus.dma_m_access = 1'b1;
        wait_acks(base + 6);
        bus.instr_m_access = 1'b0; bus.data_m_access = 1'b0; bus.dma_m_access = 1'b0;
        repeat (8) tick();
        check_eq("rr_ack_count", n_acks - base, 6);
        check_eq("rr_sb_empty", sb.size(), 0);

        // Single DATA read of 0x00100 returning BEEF
        force_en = 1'b1; force_data = 16'hBEEF;
        bus.data_m_addr = 19'h00100; bus.data_m_wr_en = 1'b0; bus.data_m_bytesel = 2'b11;
        base = n_acks;
        sb.push_back('{id: 2'd1, data: 16'hBEEF});
        bus.data_m_access = 1'b1;
        #1;
        check_eq("rd_decision_cycle_access", bus.q_m_access, 0);
        tick();
        check_eq("rd_access_rise", bus.q_m_access, 1);
        check_eq("rd_addr", bus.q_m_addr, 19'h00100);
        rise = cyc;
        wait_acks(base + 1);
        check_eq("rd_ack_latency", cyc - rise, 3);
        tick();
        check_eq("rd_ack_pulse", bus.data_m_ack, 0);
        check_eq("rd_idle_bubble", bus.q_m_access, 0);
        bus.data_m_access = 1'b0;
        force_en = 1'b0;
        tick();

        // INSTR fetch while the data master presents a byte write (not requesting)
        bus.data_m_wr_en = 1'b1; bus.data_m_bytesel = 2'b01; bus.data_m_data_out = 16'hFFFF;
        bus.instr_m_addr = 19'h00ABC;
        sb.push_back('{id: 2'd0, data: mem_rd(19'h00ABC)});
        bus.instr_m_access = 1'b1;
        watch_busy("instr_ctl", {19'h00ABC, 16'h0000, 1'b0, 2'b11});
        bus.instr_m_access = 1'b0;
        bus.data_m_wr_en = 1'b0; bus.data_m_bytesel = 2'b11; bus.data_m_data_out = 16'h0;
        tick();

        // DMA write of 1234 to the upper byte lane
        bus.dma_m_addr = 19'h04000; bus.dma_m_data_out = 16'h1234;
        bus.dma_m_wr_en = 1'b1; bus.dma_m_bytesel = 2'b10;
        sb.push_back('{id: 2'd2, data: mem_rd(19'h04000)});
        bus.dma_m_access = 1'b1;
        watch_busy("dma_wr_ctl", {19'h04000, 16'h1234, 1'b1, 2'b10});
        bus.dma_m_access = 1'b0; bus.dma_m_wr_en = 1'b0; bus.dma_m_bytesel = 2'b11;
        tick();

        // Silent slave
        slave_en = 1'b0;
        bus.data_m_addr = 19'h05000;
        base = n_acks;
`ifdef QBUS_ARB_ACK_TIMEOUT_EN
        sb.push_back('{id: 2'd1, data: 16'hFFFF});
        bus.data_m_access = 1'b1;
        wait_access("to_access_rise");
        busy = 1;
        g = 0;
        while (!bus.data_m_ack && g < 40) begin
            tick();
            busy++;
            g++;
        end
        check_eq("to_busy_cycles", busy, 8);
        check_eq("to_access_low", bus.q_m_access, 0);
        bus.data_m_access = 1'b0;
        slave_en = 1'b1;
        tick();
        check_eq("to_bus_error_set", bus.bus_error, 1);
        bus.bus_error_clr = 1'b1;
        tick();
        bus.bus_error_clr = 1'b0;
        check_eq("to_bus_error_clr", bus.bus_error, 0);
        check_eq("to_ack_count", n_acks - base, 1);
`else
        bus.data_m_access = 1'b1;
        repeat (20) tick();
        check_eq("noto_still_waiting", n_acks - base, 0);
        check_eq("noto_access_held", bus.q_m_access, 1);
        check_eq("noto_bus_error", bus.bus_error, 0);
        sb.push_back('{id: 2'd1, data: mem_rd(19'h05000)});
        slave_en = 1'b1;
        wait_acks(base + 1);
        bus.data_m_access = 1'b0;
`endif
        tick();

        // Reset in the second BUSY cycle
        slave_lat = 10;
        bus.dma_m_addr = 19'h06000;
        sb.push_back('{id: 2'd2, data: mem_rd(19'h06000)});
        bus.dma_m_access = 1'b1;
        wait_access("rst_busy_start");
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_access", bus.q_m_access, 0);
        check_eq("midrst_acks", {bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack}, 0);
        sb.delete();
        bus.dma_m_access = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        slave_lat = 3;
        base = n_acks;
        bus.data_m_addr = 19'h07000; bus.instr_m_addr = 19'h07100; bus.dma_m_addr = 19'h07200;
        sb.push_back('{id: 2'd1, data: mem_rd(19'h07000)});
        bus.instr_m_access = 1'b1; bus.data_m_access = 1'b1; bus.dma_m_access = 1'b1;
        wait_acks(base + 1);
        bus.instr_m_access = 1'b0; bus.data_m_access = 1'b0; bus.dma_m_access = 1'b0;
        repeat (5) tick();
        check_eq("postrst_ack_count", n_acks - base, 1);
        check_eq("postrst_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/qbus_arbiter3.md
Name: qbus_arbiter3

Overview:
- Three-master arbiter for the shared multiplexed memory bus (q_m_*) feeding SDRAM controller and BIOS ROM.
- Masters: CPU instruction bus, CPU data bus, DMA engine (e.g. SPI/UART block transfers).
- Round-robin fairness; one outstanding transaction; grant held until slave ack.
- Replaces the two-master arbiter once DMA is introduced.

Parameters:
- TIMEOUT, 1024, cycles in BUSY without q_m_ack before forced completion (only with ACK_TIMEOUT_EN); minimum 4.
- CNT_W, 11, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_m_addr  in  19  instruction word address [19:1]
- instr_m_access  in  1  instruction request, held until ack
- instr_m_ack  out  1  one-cycle completion pulse
- instr_m_data_in  out  16  read data to instruction master
- data_m_addr  in  19  data word address
- data_m_data_out  in  16  write data from data master
- data_m_access  in  1  data request
- data_m_wr_en  in  1  write enable
- data_m_bytesel  in  2  byte lanes
- data_m_ack  out  1  completion pulse
- data_m_data_in  out  16  read data
- dma_m_addr  in  19  DMA word address
- dma_m_data_out  in  16  DMA write data
- dma_m_access  in  1  DMA request
- dma_m_wr_en  in  1  write enable
- dma_m_bytesel  in  2  byte lanes
- dma_m_ack  out  1  completion pulse
- dma_m_data_in  out  16  read data
- q_m_addr  out  19  shared bus address
- q_m_data_out  out  16  shared bus write data
- q_m_access  out  1  shared bus request
- q_m_wr_en  out  1  shared bus write enable
- q_m_bytesel  out  2  shared bus byte lanes
- q_m_ack  in  1  slave completion (OR of slave acks)
- q_m_data_in  in  16  slave read data (OR of slave data)
- bus_error  out  1  sticky timeout flag
- bus_error_clr  in  1  clears bus_error

Behaviour:
- Reset values: state IDLE, grant none, last winner = INSTR, all *_ack 0, q_m_access 0, bus_error 0, counter 0.
- Master indices: INSTR=0, DATA=1, DMA=2.
- IDLE: if any *_access is high, pick the first requester scanning from (last+1) mod 3 upward.
  - Latch the grant and last winner; go BUSY next cycle.
  - q_m_access stays 0 in the decision cycle.
- BUSY:
  - q_m_access = 1.
  - q_m_addr, wr_en, bytesel and data_out are muxed combinationally from the granted master's live signals.
  - Masters hold their signals stable until ack; a master dropping access mid-transaction is a protocol violation. The arbiter ignores it and completes the transaction.
- INSTR grant: q_m_wr_en = 0, q_m_bytesel = 2'b11, q_m_data_out = 0.
- No grant: all q_m_* outputs are 0.
- Completion: q_m_ack in BUSY is routed combinationally to the granted master's ack in the same cycle.
  - q_m_data_in is routed to the granted master's data_in; non-granted data_in = 0 at all times.
  - Next state is IDLE. There is a mandatory one-cycle IDLE bubble before re-arbitration.
- q_m_ack outside BUSY is ignored.
- Throughput: at most one transaction per (slave latency + 2) cycles.
- Simultaneous requests from all three, continuously re-asserted: grants rotate DATA, DMA, INSTR, DATA, and so on.
- Fairness: no master waits more than two other transactions.
- Async reset mid-BUSY: q_m_access and acks drop immediately, no ack is generated, and the state returns to IDLE.
- bus_error_clr: clears bus_error in the next cycle. If a timeout fires in the same cycle, set wins.

Optional Feature:
- Macro: QBUS_ARB_ACK_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without q_m_ack.
  - When the count reaches TIMEOUT-1 with no ack, the arbiter:
    - pulses the granted master's ack for one cycle with data_in = 16'hFFFF;
    - deasserts q_m_access in that cycle;
    - sets bus_error;
    - returns to IDLE.
  - A real q_m_ack in the same cycle takes precedence: normal completion, no error.
- Undefined: no counter; BUSY waits indefinitely; bus_error tied 0; bus_error_clr unused.

Test Plan:
- Single DATA read to 0x00100 with slave acking 3 cycles after q_m_access and q_m_data_in=16'hBEEF:
  - q_m_access rises 1 cycle after data_m_access;
  - data_m_ack is a 1-cycle pulse with data_m_data_in=16'hBEEF;
  - instr/dma data_in stay 0.
- All three masters request continuously for 6 transactions:
  - grant order DATA, DMA, INSTR, DATA, DMA, INSTR;
  - exactly one ack per transaction to the correct master.
- INSTR fetch while data master presents wr_en=1, bytesel=2'b01:
  - q_m_wr_en=0, q_m_bytesel=2'b11 throughout the INSTR grant.
- DMA write of 16'h1234, bytesel=2'b10: q_m_data_out=16'h1234, q_m_wr_en=1, q_m_bytesel=2'b10 until ack.
- Reset asserted in the second BUSY cycle: q_m_access and acks are 0 within the same cycle; after release, the first grant goes to DATA.
- With QBUS_ARB_ACK_TIMEOUT_EN and TIMEOUT=8, slave never acks:
  - requester ack pulses after 8 BUSY cycles with data 16'hFFFF;
  - bus_error=1;
  - bus_error_clr pulse returns it to 0.
